// File: rtl/range_counter_if.sv
// rtl/range_counter_if.sv - control/status bundle for range_counter
// The master drives the controls, and the slave (the counter) returns count and status.
interface range_counter_if #(
  parameter int WIDTH  = 3,
  parameter int WRAP_W = 8
);
  logic              en;
  logic              up;
  logic              clr;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic [WIDTH-1:0]  count;
  logic              at_hi;
  logic              at_lo;
  logic              tc;
  logic              wrap;
  logic [WRAP_W-1:0] wrap_cnt;

  modport master (
    output en, up, clr, load, load_val,
    input  count, at_hi, at_lo, tc, wrap, wrap_cnt
  );

  modport slave (
    input  en, up, clr, load, load_val,
    output count, at_hi, at_lo, tc, wrap, wrap_cnt
  );
endinterface

// File: rtl/range_counter.sv
// rtl/range_counter.sv - up/down modulo counter over [LO,HI] with wrap/saturate and wrap tally
// Priority of the synchronous actions is clr, then load, then en.
module range_counter #(
  parameter int WIDTH    = 3,
  parameter int LO       = 1,
  parameter int HI       = 5,
  parameter int SATURATE = 0,
  parameter int WRAP_W   = 8
) (
  input logic            clk,
  input logic            rst,
  range_counter_if.slave bus
);

  if (LO < 0 || LO >= HI || HI > (2**WIDTH) - 1) begin : g_bad_params
    $error("range_counter: LO/HI illegal for WIDTH");
  end

  localparam logic [WIDTH-1:0] LO_V = WIDTH'(LO);
  localparam logic [WIDTH-1:0] HI_V = WIDTH'(HI);
  localparam bit               SAT  = (SATURATE != 0);

  logic [WIDTH-1:0]  r_count;
  logic              r_wrap;
  logic [WRAP_W-1:0] r_wrap_cnt;
  logic [WIDTH-1:0]  w_count_nxt;
  logic [WIDTH-1:0]  w_load_clamped;
  logic              w_at_hi;
  logic              w_at_lo;
  logic              w_at_end;
  logic              w_wrap_step;

  assign w_at_hi  = (r_count == HI_V);
  assign w_at_lo  = (r_count == LO_V);
  assign w_at_end = bus.up ? w_at_hi : w_at_lo;

  // A wrap only happens on a plain count step that hits the end in the current direction.
  assign w_wrap_step = !SAT && !bus.clr && !bus.load && bus.en && w_at_end;

  always_comb begin
    w_load_clamped = bus.load_val;
    if (bus.load_val < LO_V) begin
      w_load_clamped = LO_V;
    end else if (bus.load_val > HI_V) begin
      w_load_clamped = HI_V;
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    if (bus.clr) begin
      w_count_nxt = LO_V;
    end else if (bus.load) begin
      w_count_nxt = w_load_clamped;
    end else if (bus.en) begin
      if (w_at_end) begin
        if (!SAT) begin
          w_count_nxt = bus.up ? LO_V : HI_V;
        end
      end else begin
        w_count_nxt = bus.up ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= LO_V;
      r_wrap     <= 1'b0;
      r_wrap_cnt <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_wrap  <= w_wrap_step;
      if (bus.clr) begin
        r_wrap_cnt <= '0;
      end else if (w_wrap_step && (r_wrap_cnt != '1)) begin
        r_wrap_cnt <= r_wrap_cnt + WRAP_W'(1);
      end
    end
  end

  assign bus.count    = r_count;
  assign bus.at_hi    = w_at_hi;
  assign bus.at_lo    = w_at_lo;
  assign bus.tc       = bus.en & w_at_end;
  assign bus.wrap     = r_wrap;
  assign bus.wrap_cnt = r_wrap_cnt;

endmodule

// File: tb/tb_range_counter.sv
// tb/tb_range_counter.sv - self-checking bench for range_counter, wrapping and saturating builds
module tb_range_counter;
  localparam int LO = 1;
  localparam int HI = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up, clr, load;
  logic [2:0] load_val;

  int tests = 0;
  int fails = 0;
  int m_cnt, m_wrap, m_wc, s_cnt;

  range_counter_if #(.WIDTH(3), .WRAP_W(8)) if0 ();
  range_counter_if #(.WIDTH(3), .WRAP_W(8)) if1 ();

  assign if0.en = en;  assign if0.up = up;  assign if0.clr = clr;
  assign if0.load = load;  assign if0.load_val = load_val;
  assign if1.en = en;  assign if1.up = up;  assign if1.clr = clr;
  assign if1.load = load;  assign if1.load_val = load_val;

  range_counter #(.WIDTH(3), .LO(LO), .HI(HI), .SATURATE(0), .WRAP_W(8)) u_dut (
    .clk(clk), .rst(rst), .bus(if0.slave)
  );
  range_counter #(.WIDTH(3), .LO(LO), .HI(HI), .SATURATE(1), .WRAP_W(8)) u_dut_sat (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int nxt(input int c, input bit sat, input bit e, input bit u,
                             input bit cl, input bit ld, input int lv, output bit wrapped);
    wrapped = 1'b0;
    if (cl) return LO;
    if (ld) return (lv < LO) ? LO : ((lv > HI) ? HI : lv);
    if (!e) return c;
    if (u && c < HI) return c + 1;
    if (!u && c > LO) return c - 1;
    if (sat) return c;
    wrapped = 1'b1;
    return u ? LO : HI;
  endfunction

  task automatic model_reset();
    m_cnt = LO; m_wrap = 0; m_wc = 0; s_cnt = LO;
  endtask

  task automatic step(input bit e, input bit u, input bit cl, input bit ld, input int lv);
    bit w0, w1;
    en = e; up = u; clr = cl; load = ld; load_val = lv[2:0];
    #1;
    chk("at_hi", if0.at_hi, 32'(m_cnt == HI));
    chk("at_lo", if0.at_lo, 32'(m_cnt == LO));
    chk("tc", if0.tc, 32'(e && (u ? (m_cnt == HI) : (m_cnt == LO))));
    @(posedge clk);
    #1;
    m_cnt  = nxt(m_cnt, 1'b0, e, u, cl, ld, lv, w0);
    m_wrap = int'(w0);
    if (cl) m_wc = 0;
    else if (w0 && m_wc < 255) m_wc++;
    s_cnt = nxt(s_cnt, 1'b1, e, u, cl, ld, lv, w1);
    chk("count", if0.count, m_cnt);
    chk("wrap", if0.wrap, m_wrap);
    chk("wrap_cnt", if0.wrap_cnt, m_wc);
    chk("sat_count", if1.count, s_cnt);
    chk("sat_wrap", if1.wrap, 0);
    chk("sat_wrap_cnt", if1.wrap_cnt, 0);
  endtask

  initial begin
    int seq1[6];
    int seq2[6];
    seq1 = '{2, 3, 4, 5, 1, 2};
    seq2 = '{5, 4, 3, 2, 1, 5};
    en = 0; up = 1; clr = 0; load = 0; load_val = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_count", if0.count, LO);
    chk("rst_wrap", if0.wrap, 0);
    chk("rst_wrap_cnt", if0.wrap_cnt, 0);
    chk("rst_sat_count", if1.count, LO);
    @(negedge clk) rst = 1'b0;

    // up through the 5->1 wrap
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 0, 0, 0);
      chk("t1_count", if0.count, seq1[i]);
      chk("t1_wrap", if0.wrap, 32'(i == 4));
    end
    chk("t1_wrap_cnt", if0.wrap_cnt, 1);

    // down from 1, 1->5 is a wrap
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 0, 0);
      chk("t2_count", if0.count, seq2[i]);
    end
    chk("t2_wrap_cnt", if0.wrap_cnt, 2);

    // saturating build holds at both ends
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 0);
    chk("t3_sat_hi", if1.count, HI);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0);
    chk("t3_sat_lo", if1.count, LO);

    // load clamping, then clr beats load
    step(1, 1, 0, 1, 7);  chk("t4_load7", if0.count, 5);
    step(1, 1, 0, 1, 0);  chk("t4_load0", if0.count, 1);
    step(1, 0, 0, 1, 3);  chk("t4_load3", if0.count, 3);
    step(1, 1, 1, 1, 4);
    chk("t4_clr_count", if0.count, 1);
    chk("t4_clr_wrap_cnt", if0.wrap_cnt, 0);

    // asynchronous reset mid-count
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
    chk("t5_pre", if0.count, 4);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("t5_async_count", if0.count, LO);
    chk("t5_async_wrap_cnt", if0.wrap_cnt, 0);
    @(negedge clk) rst = 1'b0;
    step(1, 1, 0, 0, 0);
    chk("t5_resume", if0.count, 2);

    // more than 256 wraps saturate the tally
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 256 * 5 + 5; i++) step(1, 1, 0, 0, 0);
    chk("t6_wrap_cnt_sat", if0.wrap_cnt, 255);

    // randomized traffic against the model
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
           int'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
